// File: rtl/aes_byte_loader_pkg.sv
// aes_byte_loader_pkg: shared widths and FSM state encodings for the AES byte loader
package aes_byte_loader_pkg;

    localparam int AES_W       = 128;
    localparam int BLOCK_BYTES = 16;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        S_LOAD_KEY  = 2'd0,
        S_LOAD_DATA = 2'd1,
        S_FIRE      = 2'd2,
        S_WAIT      = 2'd3
    } state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// aes_byte_shifter: MSB-first byte assembler with a byte counter and a 16th-byte wrap flag
module aes_byte_shifter
    import aes_byte_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic [7:0]   byte_i,
    output logic [127:0] next_o,
    output logic         wrap_o
);

    // Only the first 15 bytes need storing; the 16th arrives on byte_i at commit time.
    logic [AES_W-9:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign next_o = {acc_q, byte_i};
    assign wrap_o = shift_i && (cnt_q == CNT_W'(BLOCK_BYTES - 1));

    // Shift in accepted bytes; clear wins over shift; the counter wraps naturally.
    always_comb begin
        acc_d = clr_i ? '0 : shift_i ? next_o[AES_W-9:0] : acc_q;
        cnt_d = clr_i ? '0 : shift_i ? cnt_q + 1'b1 : cnt_q;
    end

    // Assembly register and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_byte_loader.sv
// aes_byte_loader: byte-serial key/block loader with start/done handshake; AES_LOADER_KEEP_KEY_EN adds key_keep
module aes_byte_loader
    import aes_byte_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic         flush,
    input  logic         core_done,
`ifdef AES_LOADER_KEEP_KEY_EN
    input  logic         key_keep,
`endif
    output logic [127:0] key_out,
    output logic [127:0] block_out,
    output logic         start,
    output logic         busy
);

    state_e       state_q, state_d, resume_state;
    logic [127:0] key_q, key_d, block_q, block_d, asm_next;
    logic         shift, wrap;

    // Flush drops any byte offered in the same cycle.
    assign in_ready  = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_DATA);
    assign shift     = in_valid && in_ready && !flush;
    assign start     = state_q == S_FIRE;
    assign busy      = (state_q == S_FIRE) || (state_q == S_WAIT);
    assign key_out   = key_q;
    assign block_out = block_q;

`ifdef AES_LOADER_KEEP_KEY_EN
    assign resume_state = key_keep ? S_LOAD_DATA : S_LOAD_KEY;
`else
    assign resume_state = S_LOAD_KEY;
`endif

    aes_byte_shifter u_shift (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .shift_i (shift),
        .byte_i  (in_data),
        .next_o  (asm_next),
        .wrap_o  (wrap)
    );

    // Next state and commits; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        block_d = block_q;
        if (flush) begin
            state_d = S_LOAD_KEY;
        end else begin
            case (state_q)
                S_LOAD_KEY: if (wrap) begin
                    key_d   = asm_next;
                    state_d = S_LOAD_DATA;
                end
                S_LOAD_DATA: if (wrap) begin
                    block_d = asm_next;
                    state_d = S_FIRE;
                end
                S_FIRE: state_d = S_WAIT;
                default: if (core_done) state_d = resume_state;
            endcase
        end
    end

    // State and committed key/block registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD_KEY;
            key_q   <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            block_q <= block_d;
        end
    end

endmodule
